rom_word_fetch: RTL and testbench

//  Fetch-side controller directly upstream of the 16-bit ROM half-word reader (rom_read).

---
 rtl/rom_word_fetch.sv | 189 ++++++++++++++++++
 tb/tb_rom_word_fetch.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_word_fetch.sv
// Word fetch controller: splits a 32-bit fetch into two 16-bit ROM half reads and returns the word.
// Optional one-entry fetch cache enabled by defining ROM_FETCH_CACHE_EN.
module rom_word_fetch #(
  parameter int TIMEOUT_CYC = 64,
  parameter bit LO_FIRST    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_ready,
  input  logic        cpu_flush,
  output logic        cpu_valid,
  input  logic        cpu_rready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        rd_ce,
  output logic [31:0] rd_addr,
  input  logic [15:0] rd_data,
  input  logic        rd_fin
);

  // state  | meaning
  // S_IDLE | waiting for a fetch request
  // S_RD0  | first half read in flight
  // S_GAP0 | one cycle rd_ce low between halves
  // S_RD1  | second half read in flight
  // S_GAP1 | one cycle rd_ce low before responding
  // S_RESP | response presented until consumed
  // S_GAPF | one cycle rd_ce low after a flushed read
  typedef enum logic [2:0] {S_IDLE, S_RD0, S_GAP0, S_RD1, S_GAP1, S_RESP, S_GAPF} state_t;

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state, state_nxt;
  logic [29:0]   word_q, word_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          ready_nxt, valid_nxt, err_nxt, ce_nxt;
  logic [31:0]   rdata_nxt, addr_nxt;
  logic          cache_hit;
  logic [31:0]   cache_data;

`ifdef ROM_FETCH_CACHE_EN
  logic [29:0] tag_q;
  logic        tag_vld;
  logic [31:0] data_q;
  logic        fill_en;

  // only error-free fetches that reach RESP through the read path are cached
  assign fill_en    = (state == S_GAP1) && !cpu_flush && !cpu_err;
  assign cache_hit  = tag_vld && (tag_q == cpu_addr[31:2]);
  assign cache_data = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q   <= '0;
      tag_vld <= 1'b0;
      data_q  <= '0;
    end else if (fill_en) begin
      tag_q   <= word_q;
      tag_vld <= 1'b1;
      data_q  <= cpu_rdata;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      word_q    <= '0;
      timer     <= '0;
      cpu_ready <= 1'b1;
      cpu_valid <= 1'b0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
      rd_ce     <= 1'b0;
      rd_addr   <= '0;
    end else begin
      state     <= state_nxt;
      word_q    <= word_nxt;
      timer     <= timer_nxt;
      cpu_ready <= ready_nxt;
      cpu_valid <= valid_nxt;
      cpu_rdata <= rdata_nxt;
      cpu_err   <= err_nxt;
      rd_ce     <= ce_nxt;
      rd_addr   <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    word_nxt  = word_q;
    timer_nxt = timer;
    ready_nxt = cpu_ready;
    valid_nxt = cpu_valid;
    rdata_nxt = cpu_rdata;
    err_nxt   = cpu_err;
    ce_nxt    = rd_ce;
    addr_nxt  = rd_addr;
    case (state)
      S_IDLE: begin
        if (cpu_req && cpu_ready && !cpu_flush) begin
          word_nxt  = cpu_addr[31:2];
          ready_nxt = 1'b0;
          if (cpu_addr[1:0] != 2'b00) begin
            state_nxt = S_RESP;
            valid_nxt = 1'b1;
            err_nxt   = 1'b1;
            rdata_nxt = '0;
          end else if (cache_hit) begin
            state_nxt = S_RESP;
            valid_nxt = 1'b1;
            err_nxt   = 1'b0;
            rdata_nxt = cache_data;
          end else begin
            state_nxt = S_RD0;
            err_nxt   = 1'b0;
            ce_nxt    = 1'b1;
            addr_nxt  = {1'b0, cpu_addr[31:2], 1'b0};
            timer_nxt = '0;
          end
        end
      end
      S_RD0, S_RD1: begin
        if (cpu_flush) begin
          ce_nxt    = 1'b0;
          valid_nxt = 1'b0;
          state_nxt = S_GAPF;
        end else if (rd_fin) begin
          ce_nxt = 1'b0;
          // first read lands in the low half when LO_FIRST, the second read in the other
          if ((state == S_RD0) == LO_FIRST) rdata_nxt[15:0] = rd_data;
          else rdata_nxt[31:16] = rd_data;
          state_nxt = (state == S_RD0) ? S_GAP0 : S_GAP1;
        end else if (timer == T_LAST) begin
          ce_nxt    = 1'b0;
          err_nxt   = 1'b1;
          rdata_nxt = '0;
          state_nxt = S_GAP1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_GAP0: begin
        if (cpu_flush) begin
          state_nxt = S_IDLE;
          ready_nxt = 1'b1;
        end else begin
          state_nxt = S_RD1;
          ce_nxt    = 1'b1;
          addr_nxt  = {1'b0, word_q, 1'b1};
          timer_nxt = '0;
        end
      end
      S_GAP1: begin
        if (cpu_flush) begin
          state_nxt = S_IDLE;
          ready_nxt = 1'b1;
        end else begin
          state_nxt = S_RESP;
          valid_nxt = 1'b1;
        end
      end
      S_GAPF: begin
        state_nxt = S_IDLE;
        ready_nxt = 1'b1;
      end
      S_RESP: begin
        if (cpu_flush || cpu_rready) begin
          state_nxt = S_IDLE;
          valid_nxt = 1'b0;
          ready_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        ready_nxt = 1'b1;
        valid_nxt = 1'b0;
        ce_nxt    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rom_word_fetch.sv
// Bench for rom_word_fetch: behavioural ROM reader, word model and per-cycle response compare.
// Exercises the ROM_FETCH_CACHE_EN variant when that macro is defined.
module tb_rom_word_fetch;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_ready;
  logic        cpu_flush = 1'b0;
  logic        cpu_valid;
  logic        cpu_rready = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        rd_ce;
  logic [31:0] rd_addr;
  logic [15:0] rd_data = '0;
  logic        rd_fin = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  rom_word_fetch #(.TIMEOUT_CYC(TO), .LO_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .cpu_flush(cpu_flush), .cpu_valid(cpu_valid), .cpu_rready(cpu_rready),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .rd_ce(rd_ce), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_fin(rd_fin)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ROM contents: two pinned halves for the literal test, a scramble elsewhere
  function automatic logic [15:0] rom_half(input logic [31:0] idx);
    if (idx == 32'd8) return 16'h1234;
    if (idx == 32'd9) return 16'hABCD;
    return 16'(idx[15:0] * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] i0, i1;
    i0 = {a[31:2], 1'b0} >> 0;
    i0 = {1'b0, a[31:2], 1'b0};
    i1 = {1'b0, a[31:2], 1'b1};
    return {rom_half(i1), rom_half(i0)};
  endfunction

  // reader model: rd_fin appears after lat cycles of rd_ce high, drops once rd_ce drops
  int          lat = 1;
  bit          hang = 1'b0;
  int          rcnt = 0;
  logic        ce_prev = 1'b0;
  logic [31:0] addr_log[$];

  always @(posedge clk) begin
    if (rst || !rd_ce) begin
      rcnt = 0;
      rd_fin <= 1'b0;
    end else if (!rd_fin && !hang) begin
      rcnt++;
      if (rcnt >= lat) begin
        rd_fin  <= 1'b1;
        rd_data <= rom_half(rd_addr);
      end
    end
    if (rd_ce && !ce_prev) addr_log.push_back(rd_addr);
    ce_prev = rd_ce;
  end

  // response compare against the model whenever a response is presented
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;
  always @(negedge clk) begin
    if (!rst && cpu_valid) begin
      check("resp_rdata", cpu_rdata, exp_rdata);
      check("resp_err", {31'd0, cpu_err}, {31'd0, exp_err});
    end
  end

  // issue one fetch, wait for the response, hold it for 'hold' cycles, then consume it
  task automatic fetch(input logic [31:0] a, input int n, input int hold, output int got_lat);
    int cyc;
    lat = n;
    exp_err   = (a[1:0] != 2'b00);
    exp_rdata = exp_err ? 32'd0 : model_word(a);
    addr_log.delete();
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = a;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1 cyc++;
    end while (!cpu_valid && cyc < 200);
    got_lat = cyc;
    if (cyc >= 200) check("resp_timeout", 32'd0, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 check("bp_valid_held", {31'd0, cpu_valid}, 32'd1);
    end
    @(negedge clk);
    cpu_rready = 1'b1;
    @(posedge clk);
    #1 cpu_rready = 1'b0;
    check("after_rready_valid", {31'd0, cpu_valid}, 32'd0);
    check("after_rready_ready", {31'd0, cpu_ready}, 32'd1);
  endtask

  initial begin
    int l;
    int cnt;
    bit saw_valid;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, cpu_ready}, 32'd1);
    check("rst_valid", {31'd0, cpu_valid}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_err", {31'd0, cpu_err}, 32'd0);
    check("rst_rd_ce", {31'd0, rd_ce}, 32'd0);
    check("rst_rd_addr", rd_addr, 32'd0);
    @(negedge clk) rst = 1'b0;

    // aligned fetch, reader latency 2: valid 2*2+4 cycles after accept
    fetch(32'h10, 2, 0, l);
    check("t1_latency", l, 32'd8);
    check("t1_model_pin", model_word(32'h10), 32'hABCD1234);
    check("t1_nreads", addr_log.size(), 32'd2);
    if (addr_log.size() == 2) begin
      check("t1_addr0", addr_log[0], 32'h8);
      check("t1_addr1", addr_log[1], 32'h9);
    end

    // misaligned: immediate error response, no reads
    fetch(32'h12, 2, 0, l);
    check("t2_latency", l, 32'd1);
    check("t2_nreads", addr_log.size(), 32'd0);

    // backpressure for five cycles
    fetch(32'h30, 1, 5, l);
    check("t3_latency", l, 32'd6);

    // other reader latencies
    for (int n = 3; n <= 5; n++) begin
      fetch(32'h100 + 32'(n * 4), n, 0, l);
      check("lat_sweep", l, 32'(2 * n + 4));
    end

    // flush on the same edge as the first rd_fin (latency 3 -> sampled 4 edges after accept)
    lat = 3;
    addr_log.delete();
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = 32'h60;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t4_fin_aligned", {31'd0, rd_fin}, 32'd1);
    cpu_flush = 1'b1;
    @(posedge clk);
    #1 cpu_flush = 1'b0;
    check("t4_ce_dropped", {31'd0, rd_ce}, 32'd0);
    check("t4_not_ready_gap", {31'd0, cpu_ready}, 32'd0);
    @(posedge clk);
    #1 check("t4_ready", {31'd0, cpu_ready}, 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (cpu_valid || rd_ce) saw_valid = 1'b1;
    end
    check("t4_no_response", {31'd0, saw_valid}, 32'd0);
    fetch(32'h20, 2, 0, l);
    check("t4_next_latency", l, 32'd8);

    // flush together with a request in IDLE: not accepted
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_flush = 1'b1;
    cpu_addr = 32'h70;
    @(posedge clk);
    #1 begin cpu_req = 1'b0; cpu_flush = 1'b0; end
    check("idle_flush_ready", {31'd0, cpu_ready}, 32'd1);
    check("idle_flush_ce", {31'd0, rd_ce}, 32'd0);

    // flush during RESP drops the response
    lat = 1;
    exp_rdata = model_word(32'h74);
    exp_err = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = 32'h74;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    cnt = 0;
    while (!cpu_valid && cnt < 50) begin
      @(posedge clk);
      #1 cnt++;
    end
    check("resp_flush_lat", cnt, 32'd6);
    @(negedge clk) cpu_flush = 1'b1;
    @(posedge clk);
    #1 cpu_flush = 1'b0;
    check("resp_flush_valid", {31'd0, cpu_valid}, 32'd0);
    check("resp_flush_ready", {31'd0, cpu_ready}, 32'd1);

    // timeout: reader never finishes
    hang = 1'b1;
    exp_rdata = 32'd0;
    exp_err = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = 32'h50;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    check("t5_ce_start", {31'd0, rd_ce}, 32'd1);
    cnt = 0;
    while (rd_ce && cnt < 100) begin
      @(posedge clk);
      #1 cnt++;
    end
    check("t5_ce_cycles", cnt, 32'(TO));
    while (!cpu_valid && cnt < 100) begin
      @(posedge clk);
      #1 cnt++;
    end
    check("t5_valid_at", cnt, 32'(TO + 1));
    check("t5_err", {31'd0, cpu_err}, 32'd1);
    @(negedge clk) cpu_rready = 1'b1;
    @(posedge clk);
    #1 cpu_rready = 1'b0;
    hang = 1'b0;

    // repeated fetch of the same word
    fetch(32'h40, 2, 0, l);
    check("t6_first_lat", l, 32'd8);
    fetch(32'h40, 2, 0, l);
`ifdef ROM_FETCH_CACHE_EN
    check("t6_hit_lat", l, 32'd1);
    check("t6_hit_nreads", addr_log.size(), 32'd0);
`else
    check("t6_repeat_lat", l, 32'd8);
    check("t6_repeat_nreads", addr_log.size(), 32'd2);
`endif

    // reset mid-read releases the reader at once
    lat = 4;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = 32'h40;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    repeat (7) @(posedge clk);
    #1 check("rst_mid_inflight", {31'd0, rd_ce}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_ce", {31'd0, rd_ce}, 32'd0);
    check("rst_mid_ready", {31'd0, cpu_ready}, 32'd1);
    check("rst_mid_addr", rd_addr, 32'd0);
    @(negedge clk) rst = 1'b0;
    fetch(32'h40, 2, 0, l);
    check("post_rst_lat", l, 32'd8);
    check("post_rst_nreads", addr_log.size(), 32'd2);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
